// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage.
// Contents: major opcodes, load/store funct3 encodings, fault cause and
// load/store FSM state enums, and an access-size helper.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_ILLEGAL  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_cause_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_t;

    // Low two funct3 bits encode the access size for both loads and stores:
    // 00 byte, 01 half, 10 word.
    function automatic logic [1:0] acc_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and extension.
// Ports:
//   i_rdata   - 32-bit word returned by data memory
//   i_addr_lo - byte offset of the load within the word
//   i_funct3  - load funct3 (LB/LH/LW/LBU/LHU)
//   o_data    - sign/zero-extended load result
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[8*i_addr_lo +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks decoded memory requests, drives a word-wide
// req/ack data-memory port with byte strobes, and returns extended load data.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start, mem_*_enable,
//   load/store_operation,
//   addr, store_data,
//   rd_addr               - decoded request from upstream
//   busy                  - stall upstream
//   done, load_*          - completion pulse and load writeback
//   fault, fault_cause    - abort pulse and sticky cause
//   dmem_*                - data memory port
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic [2:0]            load_operation,
    input  logic [2:0]            store_operation,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    input  logic [4:0]            rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic [4:0]            load_rd,
    output logic                  load_we,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-3:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    lsu_state_t   r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic         r_is_load;
    logic [2:0]   r_f3;
    logic [1:0]   r_addr_lo;
    logic [4:0]   r_rd;
    logic         r_we;
    logic [ADDR_WIDTH-3:0] r_waddr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wstrb;
    logic         r_done;
    logic         r_load_we;
    logic [31:0]  r_load_data;
    logic [4:0]   r_load_rd;
    logic         r_fault;
    fault_cause_t r_fault_cause;

    logic         w_is_load, w_is_store;
    logic [2:0]   w_f3;
    logic         w_illegal, w_misalign, w_accept, w_reject, w_timeout;
    logic [31:0]  w_wdata;
    logic [3:0]   w_wstrb;
    logic [31:0]  w_load_data;

    // Request classification, valid only while start is high in IDLE.
    always_comb begin
        w_is_load  = mem_read_enable & ~mem_write_enable;
        w_is_store = mem_write_enable & ~mem_read_enable;
        w_f3       = w_is_load ? load_operation : store_operation;
        w_illegal  = ~(w_is_load | w_is_store);
        if (w_is_load && !(load_operation inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
            w_illegal = 1'b1;
        if (w_is_store && !(store_operation inside {F3_SB, F3_SH, F3_SW}))
            w_illegal = 1'b1;
        w_misalign = ((acc_size(w_f3) == 2'b01) && addr[0]) ||
                     ((acc_size(w_f3) == 2'b10) && (addr[1:0] != 2'b00));
        w_accept   = start && (r_state == ST_IDLE) && !w_illegal && !w_misalign;
        w_reject   = start && (r_state == ST_IDLE) && (w_illegal || w_misalign);
    end

    // Store lane formatting; loads never write a byte.
    always_comb begin
        w_wdata = store_data;
        w_wstrb = 4'b0000;
        if (w_is_store) begin
            case (store_operation)
                F3_SB: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_wstrb = 4'b0001 << addr[1:0];
                end
                F3_SH: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = store_data;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // An ack in the last counted cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_f3          <= 3'd0;
            r_addr_lo     <= 2'd0;
            r_rd          <= 5'd0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= 32'd0;
            r_wstrb       <= 4'd0;
            r_done        <= 1'b0;
            r_load_we     <= 1'b0;
            r_load_data   <= 32'd0;
            r_load_rd     <= 5'd0;
            r_fault       <= 1'b0;
            r_fault_cause <= FC_NONE;
        end else begin
            r_done    <= (r_state == ST_ACCESS) && dmem_ack;
            r_load_we <= (r_state == ST_ACCESS) && dmem_ack && r_is_load;
            r_fault   <= w_reject || w_timeout;

            if (w_accept) begin
                r_cnt     <= '0;
                r_is_load <= w_is_load;
                r_f3      <= w_f3;
                r_addr_lo <= addr[1:0];
                r_rd      <= rd_addr;
                r_we      <= w_is_store;
                r_waddr   <= addr[ADDR_WIDTH-1:2];
                r_wdata   <= w_wdata;
                r_wstrb   <= w_wstrb;
            end else if ((r_state == ST_ACCESS) && !dmem_ack && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_ACCESS) && dmem_ack && r_is_load) begin
                r_load_data <= w_load_data;
                r_load_rd   <= r_rd;
            end

            if (w_timeout)     r_fault_cause <= FC_TIMEOUT;
            else if (w_reject) r_fault_cause <= w_illegal ? FC_ILLEGAL : FC_MISALIGN;
        end
    end

    lsu_load_align u_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_f3),
        .o_data    (w_load_data)
    );

    assign busy        = (r_state == ST_ACCESS) || w_accept;
    assign done        = r_done;
    assign load_data   = r_load_data;
    assign load_rd     = r_load_rd;
    assign load_we     = r_load_we;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;
    assign dmem_req    = (r_state == ST_ACCESS);
    assign dmem_we     = r_we;
    assign dmem_addr   = r_waddr;
    assign dmem_wdata  = r_wdata;
    assign dmem_wstrb  = r_wstrb;

endmodule
